// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the memory bus unit.
package mem_bus_pkg;

  // Access size encodings carried on req_size.
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  // Unshifted byte-enable mask for an access size (8 lanes wide; callers truncate).
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] mask;
    unique case (size)
      SZ_BYTE:  mask = 8'h01;
      SZ_HALF:  mask = 8'h03;
      SZ_WORD:  mask = 8'h0f;
      default:  mask = 8'hff;
    endcase
    return mask;
  endfunction

  // Natural alignment check; doubleword is only legal on a 64-bit bus.
  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] addr_lo,
                                      input logic dword_ok);
    logic ok;
    unique case (size)
      SZ_BYTE:  ok = 1'b1;
      SZ_HALF:  ok = (addr_lo[0] == 1'b0);
      SZ_WORD:  ok = (addr_lo[1:0] == 2'b00);
      default:  ok = dword_ok && (addr_lo == 3'b000);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, write replication, read extraction/extension.
module mem_lane_align
  import mem_bus_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BE_W   = DATA_W / 8,
  parameter int unsigned LANE_W = $clog2(BE_W)
) (
  input  logic [1:0]        size_i,
  input  logic [LANE_W-1:0] offset_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [BE_W-1:0]   be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] shifted;

  // Byte enables: size mask moved up to the addressed lane.
  always_comb begin
    be_o = BE_W'(size_mask(size_i)) << offset_i;
  end

  // Write data: low bytes copied into every lane so any lane offset sees them.
  always_comb begin
    unique case (size_i)
      SZ_BYTE: wdata_o = {(BE_W){wdata_i[7:0]}};
      SZ_HALF: wdata_o = {(BE_W / 2){wdata_i[15:0]}};
      SZ_WORD: wdata_o = {(BE_W / 4){wdata_i[31:0]}};
      default: wdata_o = wdata_i;
    endcase
  end

  // Read data: addressed bytes brought down to bit 0, then sign- or zero-extended.
  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    unique case (size_i)
      SZ_BYTE: rdata_o = {{(DATA_W - 8){signed_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata_o = {{(DATA_W - 16){signed_i & shifted[15]}}, shifted[15:0]};
      SZ_WORD: rdata_o = DATA_W'(shifted[31:0]);
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_bus_unit.sv
// Request/response memory bus unit: accepts one request, drives RAM strobes, returns a response.
module mem_bus_unit
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                busy,
  output logic                mem_cs,
  output logic                mem_we,
  output logic                mem_oe,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);

  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned LANE_W   = $clog2(BE_W);
  localparam int unsigned CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic        DWORD_OK = (DATA_W == 64);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [LANE_W-1:0]   off_q, off_d;

  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                mem_cs_q, mem_cs_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_oe_q, mem_oe_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [1:0]          la_size;
  logic [LANE_W-1:0]   la_off;
  logic                la_signed;
  logic [BE_W-1:0]     la_be;
  logic [DATA_W-1:0]   la_wdata;
  logic [DATA_W-1:0]   la_rdata;

  // In IDLE the aligner sees the live request (for strobes); afterwards the latched one (for reads).
  always_comb begin
    if (state_q == StIdle) begin
      la_size   = req_size;
      la_off    = req_addr[LANE_W-1:0];
      la_signed = req_signed;
    end else begin
      la_size   = size_q;
      la_off    = off_q;
      la_signed = signed_q;
    end
  end

  mem_lane_align #(
    .DATA_W (DATA_W),
    .BE_W   (BE_W),
    .LANE_W (LANE_W)
  ) u_lane_align (
    .size_i   (la_size),
    .offset_i (la_off),
    .signed_i (la_signed),
    .wdata_i  (req_wdata),
    .rdata_i  (mem_rdata),
    .be_o     (la_be),
    .wdata_o  (la_wdata),
    .rdata_o  (la_rdata)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    signed_d    = signed_q;
    off_d       = off_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    mem_cs_d    = mem_cs_q;
    mem_we_d    = mem_we_q;
    mem_oe_d    = mem_oe_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          off_d    = req_addr[LANE_W-1:0];
          if (is_aligned(req_size, req_addr[2:0], DWORD_OK)) begin
            state_d     = StAccess;
            cnt_d       = '0;
            mem_cs_d    = 1'b1;
            mem_we_d    = req_we;
            mem_oe_d    = ~req_we;
            mem_addr_d  = {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
            mem_be_d    = la_be;
            mem_wdata_d = la_wdata;
          end else begin
            // Misaligned or unsupported size: answer with an error, never touch RAM.
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      StAccess: begin
        if (mem_ready || ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT)))) begin
          // mem_ready in the timeout cycle still counts as success.
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ~mem_ready;
          rsp_rdata_d = (mem_ready && !we_q) ? la_rdata : '0;
          mem_cs_d    = 1'b0;
          mem_we_d    = 1'b0;
          mem_oe_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = '0;
          mem_wdata_d = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset clears every strobe and response immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      signed_q    <= 1'b0;
      off_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_oe_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      off_q       <= off_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_oe_q    <= mem_oe_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // req_ready is held low while reset is asserted.
  assign req_ready = (state_q == StIdle) && rst;
  assign busy      = (state_q != StIdle);

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_oe    = mem_oe_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Scoreboard bench for mem_bus_unit: byte-level reference memory, random RAM wait states.
module tb_mem_bus_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic        mem_cs, mem_we, mem_oe;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  always #5 clk = ~clk;

  mem_bus_unit #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .busy       (busy),
    .mem_cs     (mem_cs),
    .mem_we     (mem_we),
    .mem_oe     (mem_oe),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
    int          cs_cycles;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        sb[$];
  logic [7:0]  ram[1024];      // contents as modified through the DUT's strobes
  logic [7:0]  ref_mem[1024];  // contents the reference model says should be there
  int          planned_k = 0;
  int          acc_idx = 0;
  int          cs_count = 0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [3:0]  exp_be = '0;
  logic [31:0] exp_wdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] ref_read(input int addr, input int n, input logic sgn);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v |= 32'(ref_mem[addr + i]) << (8 * i);
    if (sgn && n < 4 && v[8 * n - 1]) v |= 32'hffff_ffff << (8 * n);
    return v;
  endfunction

  // Set the strobe expectations for a legal access of n bytes at addr.
  task automatic set_strobe_exp(input logic we, input int addr, input int n, input logic [31:0] wd);
    exp_we   = we;
    exp_addr = 32'(addr) & ~32'h3;
    for (int i = 0; i < 4; i++) begin
      exp_be[i]          = (i >= addr % 4) && (i < addr % 4 + n);
      exp_wdata[8*i +: 8] = wd[8*(i % n) +: 8];
    end
  endtask

  // RAM responder: checks strobes each selected cycle, answers after planned_k wait cycles.
  always @(negedge clk) begin
    if (mem_cs === 1'b1) begin
      int a;
      a = int'(mem_addr[9:0]);
      cs_count++;
      check("mem_we", 32'(mem_we), 32'(exp_we));
      check("mem_oe", 32'(mem_oe), 32'(!exp_we));
      check("mem_addr", mem_addr, exp_addr);
      check("mem_be", 32'(mem_be), 32'(exp_be));
      check("mem_wdata", mem_wdata, exp_wdata);
      if (acc_idx == planned_k) begin
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) mem_rdata[8*i +: 8] = ram[(a + i) & 1023];
        if (mem_we)
          for (int i = 0; i < 4; i++)
            if (mem_be[i]) ram[(a + i) & 1023] = mem_wdata[8*i +: 8];
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
      acc_idx++;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      acc_idx   = 0;
    end
  end

  // Monitor: every response pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_cycle", 32'(cyc), 32'(e.cyc));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("cs_cycles", 32'(cs_count), 32'(e.cs_cycles));
        cs_count = 0;
      end
    end
  end

  // Issue one request, push its expected response, then drive noise until it is answered.
  task automatic issue(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd, input int k);
    exp_t e;
    int   n, a, w, guard;
    logic ok;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk); #1;
      guard++;
    end
    if (guard >= 20) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: got req_ready=%b, expected 1 within 20 cycles", req_ready);
      return;
    end
    a  = int'(addr);
    n  = 1 << sz;
    ok = (sz != 2'd3) && (a % n == 0);
    w  = (k < T) ? k : T;
    e.cyc       = cyc + (ok ? 2 + w : 1);
    e.err       = !ok || (k > T);
    e.rdata     = (ok && k <= T && !we) ? ref_read(a, n, sgn) : 32'h0;
    e.cs_cycles = ok ? w + 1 : 0;
    if (ok && k <= T && we)
      for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
    if (ok) set_strobe_exp(we, a, n, wd);
    planned_k = k;
    sb.push_back(e);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wd;
    @(negedge clk); #1;
    guard = 0;
    // While busy, random requests must be ignored.
    while (sb.size() != 0 && guard < 40) begin
      req_valid  = 1'($urandom);
      req_we     = 1'($urandom);
      req_size   = 2'($urandom);
      req_signed = 1'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      @(negedge clk); #1;
      guard++;
    end
    req_valid = 1'b0;
    if (guard >= 40) begin
      checks++;
      errors++;
      $display("FAIL rsp_wait: got no response, expected one within 40 cycles");
      sb.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_cs"}, 32'(mem_cs), 32'h0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    check({tag, "_mem_oe"}, 32'(mem_oe), 32'h0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_be"}, 32'(mem_be), 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] addr;
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    // Reset state.
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("reset_req_ready", 32'(req_ready), 32'h1);
    check("reset_busy", 32'(busy), 32'h0);

    // Word read, zero wait states.
    {ram[259], ram[258], ram[257], ram[256]} = 32'hdead_beef;
    {ref_mem[259], ref_mem[258], ref_mem[257], ref_mem[256]} = 32'hdead_beef;
    issue(1'b0, 2'd2, 1'b0, 32'h100, $urandom, 0);
    // Signed and unsigned byte read from the top lane.
    ram[259] = 8'h80;
    ref_mem[259] = 8'h80;
    issue(1'b0, 2'd0, 1'b1, 32'h103, $urandom, 0);
    issue(1'b0, 2'd0, 1'b0, 32'h103, $urandom, 1);
    // Halfword write in the upper half, three wait states, then read it back.
    issue(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_1234, 3);
    issue(1'b0, 2'd2, 1'b0, 32'h200, $urandom, 2);
    // Misaligned halfword and doubleword on a 32-bit bus.
    issue(1'b0, 2'd1, 1'b0, 32'h201, $urandom, 0);
    issue(1'b1, 2'd3, 1'b0, 32'h000, $urandom, 0);
    // Timeout, and ready arriving exactly in the timeout cycle.
    issue(1'b0, 2'd2, 1'b0, 32'h300, $urandom, T + 1);
    issue(1'b0, 2'd2, 1'b0, 32'h304, $urandom, T);

    // Reset pulled in the second ACCESS cycle: everything drops, no response.
    while (req_ready !== 1'b1) begin @(negedge clk); #1; end
    planned_k = 100;
    set_strobe_exp(1'b0, 32'h100, 4, 32'h5555_aaaa);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h100; req_wdata = 32'h5555_aaaa;
    @(negedge clk); #1;
    req_valid = 1'b0;
    check("access_busy", 32'(busy), 32'h1);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    cs_count = 0;
    issue(1'b0, 2'd2, 1'b0, 32'h100, $urandom, 1);

    // Random traffic, mostly aligned, wait states spanning the timeout.
    for (int t = 0; t < 200; t++) begin
      sz   = 2'($urandom);
      addr = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) addr &= ~((32'h1 << sz) - 32'h1);
      issue(1'($urandom), sz, 1'($urandom), addr, $urandom, $urandom_range(0, T + 2));
    end

    repeat (4) @(negedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_unit.md
# mem_bus_unit

Parametrised memory bus unit between the core's memory-request logic (MAR / MRDR / MWDR path) and external RAM. It replaces the fixed `cs=1, we=0, oe=1` tie-offs with a real request/response handshake. It performs read and write accesses of byte, halfword, word and (at DATA_W=64) doubleword size, with byte-enable generation and sign/zero extension. It also adds alignment checking and a wait-state timeout, neither of which the current path has.

## Interface
Parameters:
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 32: memory data width. Legal values are 32 and 64. `BE_W = DATA_W/8`. `LANE_W = log2(BE_W)`.
- `TIMEOUT`, 255: maximum wait cycles in ACCESS before error. 0 disables the timeout.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request this cycle.
- `req_we`  in  1  1 = write, 0 = read.
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 doubleword.
- `req_signed`  in  1  sign-extend read data (byte/halfword only).
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  DATA_W  write data, right-justified.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_err`  out  1  response is an error; qualified by `rsp_valid`.
- `rsp_rdata`  out  DATA_W  extended read data; 0 for writes and errors.
- `busy`  out  1  state is not IDLE.
- `mem_cs`, `mem_we`, `mem_oe`  out  1 each  RAM strobes.
- `mem_addr`  out  ADDR_W  lane-aligned address; low LANE_W bits are 0.
- `mem_be`  out  BE_W  byte enables.
- `mem_wdata`  out  DATA_W  lane-replicated write data.
- `mem_rdata`  in  DATA_W  RAM read data.
- `mem_ready`  in  1  RAM completes the access this cycle.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: `req_ready`=1. A request is accepted on `req_valid & req_ready`; all request fields are registered at acceptance.
- Legality check at acceptance:
  - halfword requires addr[0]=0;
  - word requires addr[1:0]=0;
  - doubleword requires DATA_W=64 and addr[2:0]=0.
- Illegal request: go to RESP with err=1. No memory strobe is asserted.
- Legal request: go to ACCESS.
- ACCESS outputs:
  - `mem_cs`=1;
  - `mem_we`=`req_we`, `mem_oe`=!`req_we`;
  - `mem_be` = size mask shifted by the lane offset (byte 0001, half 0011, word 1111, dword all ones), e.g. byte at addr 0x3 gives be=1000;
  - `mem_wdata` = `req_wdata` low bytes replicated across all lanes.
- ACCESS wait counter:
  - cleared on entry, +1 per cycle while `mem_ready`=0;
  - saturates, never wraps.
- `mem_ready`=1 in ACCESS ends the access and the FSM goes to RESP.
  - On a read, the addressed bytes of `mem_rdata` are shifted to bit 0.
  - Byte and halfword reads are sign-extended if `req_signed`, else zero-extended.
  - `req_signed` is ignored for word and dword.
- Timeout: TIMEOUT≠0 and counter==TIMEOUT with `mem_ready`=0 → RESP with err=1, rdata=0, strobes dropped. A `mem_ready` arriving in that same cycle wins: the access succeeds.
- RESP: `rsp_valid`=1 for exactly one cycle, then IDLE. There is no response back-pressure.
- One outstanding request only. `req_valid` while busy is ignored and not queued.

## Timing
- Reset (rst low, asynchronous):
  - state=IDLE;
  - `req_ready`=1 once rst is high;
  - `rsp_valid`, `rsp_err`, `busy`, `mem_cs`, `mem_we`, `mem_oe`=0;
  - `mem_addr`, `mem_be`, `mem_wdata`, `rsp_rdata`=0;
  - wait counter=0.
- Reset mid-ACCESS: strobes drop immediately, no response is issued, and the request is lost.
- Accept at edge N → ACCESS during cycle N+1. With `mem_ready` first high in cycle N+1+k, `rsp_valid` is high in cycle N+2+k.
- Minimum latency is 2 cycles (k=0). Back-to-back throughput is one request per 3 cycles.
- Illegal request: `rsp_valid` in cycle N+1.
- All `mem_*` and `rsp_*` outputs are registered. `req_ready` and `busy` decode directly from state.
- `mem_rdata` is sampled only in a cycle where `mem_ready`=1.

## Structure
- Package `mem_bus_pkg`: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD), the state enum, and `size_mask` / `is_aligned` functions.
- Sub-module `mem_lane_align`, purely combinational:
  - inputs: size, lane offset, signed flag, raw data;
  - outputs: `mem_be`, replicated write data, extended read data.
- The top level holds the FSM, the wait counter and the output registers.

## Test plan
- Word read at 0x100, `mem_rdata`=0xDEADBEEF, `mem_ready` high on first ACCESS cycle → `rsp_valid` 2 cycles after accept, rdata=0xDEADBEEF, err=0, be=1111, oe=1, we=0.
- Signed byte read at 0x103, rdata=0x80xxxxxx → rdata=0xFFFFFF80, be=1000. The same read unsigned → 0x00000080.
- Halfword write at 0x202, wdata=0x1234 → mem_addr=0x200, be=1100, mem_wdata=0x12341234, we=1. After 3 wait cycles, `rsp_valid` in the cycle after `mem_ready`.
- Halfword at 0x201 → err=1 one cycle after accept, `mem_cs` never asserts. Size 11 at DATA_W=32 → err=1.
- TIMEOUT=4 with `mem_ready` held 0 → err=1, rdata=0, strobes low after 4 wait cycles. Ready asserted in the timeout cycle → success.
- rst pulled low in the 2nd ACCESS cycle → all outputs 0 asynchronously, no `rsp_valid`. After release, a new word read completes normally.
